// File: rtl/uart_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl_if
// Brief    : Producer, FIFO and UART-TX signals of uart_fifo_ctrl.
//            master = controller view, slave = surrounding logic view.
// Revision : 1.0
// ============================================================================
interface uart_fifo_ctrl_if #(
    parameter int DATA_W = 12,
    parameter int LVL_W  = 11
);
    logic              s0_valid;
    logic              s0_ready;
    logic [DATA_W-1:0] s0_data;
    logic              s1_valid;
    logic              s1_ready;
    logic [DATA_W-1:0] s1_data;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_wr_full;
    logic              fifo_almost_full;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic [LVL_W-1:0]  fifo_rd_level;
    logic              tx_valid;
    logic [7:0]        tx_byte;
    logic              tx_ready;
    logic              overflow_err;

    modport master (
        input  s0_valid, s0_data, s1_valid, s1_data,
        output s0_ready, s1_ready,
        output fifo_wr_en, fifo_wr_data,
        input  fifo_wr_full, fifo_almost_full,
        output fifo_rd_en,
        input  fifo_rd_data, fifo_rd_empty, fifo_rd_level,
        output tx_valid, tx_byte,
        input  tx_ready,
        output overflow_err
    );

    modport slave (
        output s0_valid, s0_data, s1_valid, s1_data,
        input  s0_ready, s1_ready,
        input  fifo_wr_en, fifo_wr_data,
        output fifo_wr_full, fifo_almost_full,
        input  fifo_rd_en,
        output fifo_rd_data, fifo_rd_empty, fifo_rd_level,
        input  tx_valid, tx_byte,
        output tx_ready,
        input  overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Brief    : Two-producer write arbiter and burst read sequencer (word -> two
//            bytes) around uart_fifo. Option: UART_FIFO_CTRL_STRICT_PRIO_EN.
// Revision : 1.0
// ============================================================================
module uart_fifo_ctrl #(
    parameter int DATA_W      = 12,
    parameter int LVL_W       = 11,
    parameter int BURST_MIN   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  wire logic         clk,
    input  wire logic         tb_rst,
    uart_fifo_ctrl_if.master  bus
);
    localparam int                 c_CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [LVL_W-1:0]   c_BURST_LVL = LVL_W'(BURST_MIN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND_HI = 3'd3,
        ST_SEND_LO = 3'd4
    } state_t;

    logic w_grant0;
    logic w_grant1;
    logic w_acc0;
    logic w_acc1;

`ifdef UART_FIFO_CTRL_STRICT_PRIO_EN
    assign w_grant0 = bus.s0_valid;
    assign w_grant1 = bus.s1_valid & ~bus.s0_valid;
`else
    // r_last1 = producer 1 was served last, so producer 0 wins the next tie
    logic r_last1;

    assign w_grant0 = bus.s0_valid & (~bus.s1_valid | r_last1);
    assign w_grant1 = bus.s1_valid & (~bus.s0_valid | ~r_last1);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_last1 <= 1'b1;
        end else if (w_acc0) begin
            r_last1 <= 1'b0;
        end else if (w_acc1) begin
            r_last1 <= 1'b1;
        end
    end
`endif

    assign bus.s0_ready = w_grant0 & ~bus.fifo_almost_full;
    assign bus.s1_ready = w_grant1 & ~bus.fifo_almost_full;
    assign w_acc0       = w_grant0 & ~bus.fifo_almost_full;
    assign w_acc1       = w_grant1 & ~bus.fifo_almost_full;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_wr_data <= '0;
            bus.overflow_err <= 1'b0;
        end else begin
            bus.fifo_wr_en <= w_acc0 | w_acc1;
            if (w_acc0) begin
                bus.fifo_wr_data <= bus.s0_data;
            end else if (w_acc1) begin
                bus.fifo_wr_data <= bus.s1_data;
            end
            if (bus.fifo_wr_en && bus.fifo_wr_full) begin
                bus.overflow_err <= 1'b1;
            end
        end
    end

    state_t             r_state;
    logic [c_CNT_W-1:0] r_idle_cnt;
    logic [7:0]         r_word_lo;
    logic               w_trigger;

    assign w_trigger = ~bus.fifo_rd_empty &
                       ((bus.fifo_rd_level >= c_BURST_LVL) || (r_idle_cnt == c_CNT_LAST));

    // The high nibble goes straight to tx_byte at capture; only the low byte is kept.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state        <= ST_IDLE;
            r_idle_cnt     <= '0;
            r_word_lo      <= '0;
            bus.fifo_rd_en <= 1'b0;
            bus.tx_valid   <= 1'b0;
            bus.tx_byte    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    bus.fifo_rd_en <= 1'b0;
                    if (bus.fifo_rd_empty) begin
                        r_idle_cnt <= '0;
                    end else if (w_trigger) begin
                        r_idle_cnt     <= '0;
                        bus.fifo_rd_en <= 1'b1;
                        r_state        <= ST_FETCH;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + c_CNT_W'(1);
                    end
                end
                ST_FETCH: begin
                    bus.fifo_rd_en <= 1'b0;
                    r_state        <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_word_lo    <= bus.fifo_rd_data[7:0];
                    bus.tx_byte  <= 8'(bus.fifo_rd_data >> 8);
                    bus.tx_valid <= 1'b1;
                    r_state      <= ST_SEND_HI;
                end
                ST_SEND_HI: begin
                    if (bus.tx_ready) begin
                        bus.tx_byte <= r_word_lo;
                        r_state     <= ST_SEND_LO;
                    end
                end
                ST_SEND_LO: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        if (!bus.fifo_rd_empty) begin
                            bus.fifo_rd_en <= 1'b1;
                            r_state        <= ST_FETCH;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    bus.fifo_rd_en <= 1'b0;
                    bus.tx_valid   <= 1'b0;
                    r_state        <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Brief    : Self-checking bench for uart_fifo_ctrl with a behavioural FIFO.
// Revision : 1.0
// ============================================================================
module tb_uart_fifo_ctrl;
    localparam int DATA_W      = 12;
    localparam int LVL_W       = 11;
    localparam int TIMEOUT_CYC = 4096;
    localparam int DEPTH       = 1024;

    logic clk    = 1'b0;
    logic tb_rst = 1'b1;
    always #5 clk = ~clk;

    uart_fifo_ctrl_if #(.DATA_W(DATA_W), .LVL_W(LVL_W)) bus ();

    uart_fifo_ctrl #(
        .DATA_W(DATA_W), .LVL_W(LVL_W), .BURST_MIN(16), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .tb_rst(tb_rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur / unexpected event", name);
    endtask

    // Behavioural FIFO
    logic [DATA_W-1:0] mem [DEPTH];
    int                wp, rp, cnt;
    logic [DATA_W-1:0] rd_data_q;
    logic              force_af   = 1'b0;
    logic              force_full = 1'b0;
    logic [7:0]        exp_tx [$];
    logic [DATA_W-1:0] exp_wr [$];
    logic [DATA_W-1:0] wr_log [$];
    logic [7:0]        tx_log [$];

    assign bus.fifo_rd_data     = rd_data_q;
    assign bus.fifo_rd_empty    = (cnt == 0);
    assign bus.fifo_rd_level    = LVL_W'(cnt);
    assign bus.fifo_almost_full = force_af | (cnt >= 1020);
    assign bus.fifo_wr_full     = force_full | (cnt >= DEPTH);

    always @(posedge clk or posedge tb_rst) begin : fifo_model
        bit do_wr, do_rd;
        if (tb_rst) begin
            wp <= 0; rp <= 0; cnt <= 0; rd_data_q <= '0;
        end else begin
            do_wr = bus.fifo_wr_en && !bus.fifo_wr_full;
            do_rd = bus.fifo_rd_en && (cnt != 0);
            if (do_wr) begin
                mem[wp] <= bus.fifo_wr_data;
                wp      <= (wp + 1) % DEPTH;
                exp_tx.push_back({4'h0, bus.fifo_wr_data[11:8]});
                exp_tx.push_back(bus.fifo_wr_data[7:0]);
            end
            if (do_rd) begin
                rd_data_q <= mem[rp];
                rp        <= (rp + 1) % DEPTH;
            end
            cnt <= cnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt, first_rd, first_lvl, first_ne, first_tx, last_tx;

    // Scoreboard: handshakes push expected writes, FIFO writes push expected bytes
    always @(negedge clk) begin
        if (!tb_rst) begin
            if (bus.s0_valid && bus.s0_ready) exp_wr.push_back(bus.s0_data);
            if (bus.s1_valid && bus.s1_ready) exp_wr.push_back(bus.s1_data);
            if (bus.fifo_wr_en) begin
                wr_log.push_back(bus.fifo_wr_data);
                if (exp_wr.size() == 0) fail_now("wr_unexpected");
                else chk("wr_data", 32'(bus.fifo_wr_data), 32'(exp_wr.pop_front()));
            end
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                chk("rd_en_while_empty", 32'(bus.fifo_rd_empty), 32'd0);
            end
            if (first_lvl < 0 && bus.fifo_rd_level >= 16) first_lvl = cyc;
            if (first_ne < 0 && !bus.fifo_rd_empty) first_ne = cyc;
            if (first_tx < 0 && bus.tx_valid) first_tx = cyc;
            if (bus.tx_valid && bus.tx_ready) begin
                tx_log.push_back(bus.tx_byte);
                last_tx = cyc;
                if (exp_tx.size() == 0) fail_now("tx_unexpected");
                else chk("tx_byte", 32'(bus.tx_byte), 32'(exp_tx.pop_front()));
            end
        end
    end

    task automatic clear_sb();
        exp_wr.delete(); exp_tx.delete(); wr_log.delete(); tx_log.delete();
        rd_cnt = 0; first_rd = -1; first_lvl = -1; first_ne = -1; first_tx = -1; last_tx = -1;
    endtask

    task automatic drive_idle();
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        bus.s0_data  = '0;   bus.s1_data  = '0;
        bus.tx_ready = 1'b0; force_af = 1'b0; force_full = 1'b0;
    endtask

    // Leaves the caller at posedge+1 with reset released
    task automatic do_reset();
        @(negedge clk); #1;
        tb_rst = 1'b1;
        drive_idle();
        clear_sb();
        repeat (2) @(posedge clk);
        #1 tb_rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after acceptance
    task automatic write_word(input bit src, input logic [DATA_W-1:0] d);
        int n = 0;
        if (src) begin bus.s1_valid = 1'b1; bus.s1_data = d; end
        else     begin bus.s0_valid = 1'b1; bus.s0_data = d; end
        @(negedge clk);
        while (!(src ? bus.s1_ready : bus.s0_ready) && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) fail_now("write_accept_timeout");
        @(posedge clk); #1;
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            k++;
            @(posedge clk);
        end
        if (k >= budget) fail_now("tx_bytes_timeout");
        #1;
    endtask

    typedef struct packed {
        logic v0, v1, af, r0, r1;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [DATA_W-1:0] rr_exp(input int k);
`ifdef UART_FIFO_CTRL_STRICT_PRIO_EN
        return DATA_W'(12'h100 + k);
`else
        return (k % 2 == 0) ? DATA_W'(12'h100 + k / 2) : DATA_W'(12'h200 + k / 2);
`endif
    endfunction

    initial begin
        logic a0, a1;
        logic [7:0] b;
        int n0, bad, rd_before;

        // {v0, v1, af, exp r0, exp r1}; pointer starts at producer 1
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef UART_FIFO_CTRL_STRICT_PRIO_EN
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef UART_FIFO_CTRL_STRICT_PRIO_EN
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

        drive_idle();
        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readys",   {30'd0, bus.s0_ready, bus.s1_ready}, 32'd0);
        chk("rst_wr",       {19'd0, bus.fifo_wr_en, bus.fifo_wr_data}, 32'd0);
        chk("rst_rd_tx",    {22'd0, bus.fifo_rd_en, bus.tx_valid, bus.tx_byte}, 32'd0);
        chk("rst_overflow", 32'(bus.overflow_err), 32'd0);
        tb_rst = 1'b0;
        @(posedge clk); #1;

        // Arbiter table
        for (int i = 0; i < 8; i++) begin
            bus.s0_valid = vecs[i].v0; bus.s1_valid = vecs[i].v1; force_af = vecs[i].af;
            bus.s0_data  = DATA_W'(12'h100 + i);
            bus.s1_data  = DATA_W'(12'h200 + i);
            #1;
            chk($sformatf("vec%0d_s0_ready", i), 32'(bus.s0_ready), 32'(vecs[i].r0));
            chk($sformatf("vec%0d_s1_ready", i), 32'(bus.s1_ready), 32'(vecs[i].r1));
            @(posedge clk); #1;
        end
        drive_idle();
        repeat (3) @(posedge clk);
        #1 chk("table_wr_drained", exp_wr.size(), 0);

        // Round-robin fairness then backpressure
        do_reset();
        bus.tx_ready = 1'b1;
        bus.s0_data = 12'h100; bus.s1_data = 12'h200;
        bus.s0_valid = 1'b1;  bus.s1_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a0 = bus.s0_valid & bus.s0_ready;
            a1 = bus.s1_valid & bus.s1_ready;
            @(posedge clk); #1;
            if (a0) bus.s0_data = bus.s0_data + 1'b1;
            if (a1) bus.s1_data = bus.s1_data + 1'b1;
        end
        force_af = 1'b1;
        n0 = wr_log.size();
        #1 chk("bp_readys_low", {30'd0, bus.s0_ready, bus.s1_ready}, 32'd0);
        repeat (5) @(negedge clk);
        chk("bp_inflight_le1", 32'(wr_log.size() - n0 <= 1), 32'd1);
        @(posedge clk); #1;
        force_af = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a0 = bus.s0_valid & bus.s0_ready;
            a1 = bus.s1_valid & bus.s1_ready;
            @(posedge clk); #1;
            if (a0) bus.s0_data = bus.s0_data + 1'b1;
            if (a1) bus.s1_data = bus.s1_data + 1'b1;
        end
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("fair_wr_count", wr_log.size(), 12);
        chk("fair_wr_drained", exp_wr.size(), 0);
        for (int k = 0; k < 12 && k < wr_log.size(); k++)
            chk($sformatf("fair_order%0d", k), 32'(wr_log[k]), 32'(rr_exp(k)));

        // Burst threshold
        do_reset();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            write_word(1'b0, (i == 0) ? 12'hABC : DATA_W'(12'h300 + i));
        repeat (40) @(posedge clk);
        #1 chk("no_rd_below_thresh", rd_cnt, 0);
        write_word(1'b0, 12'h3FF);
        wait_tx(32, 500);
        repeat (10) @(posedge clk);
        #1;
        chk("burst_bytes", tx_log.size(), 32);
        if (tx_log.size() >= 2) begin
            chk("burst_hi_0xABC", 32'(tx_log[0]), 32'h0A);
            chk("burst_lo_0xABC", 32'(tx_log[1]), 32'hBC);
        end
        chk("burst_rd_count", rd_cnt, 16);
        chk("burst_rd_latency", first_rd - first_lvl, 1);
        chk("burst_tx_latency", first_tx - first_lvl, 3);
        chk("burst_4cyc_per_word", last_tx - first_rd, 63);
        chk("burst_tx_drained", exp_tx.size(), 0);

        // Timeout drain
        do_reset();
        bus.tx_ready = 1'b1;
        write_word(1'b1, 12'h123);
        write_word(1'b1, 12'h456);
        write_word(1'b1, 12'h789);
        for (int k = 0; k < TIMEOUT_CYC + 200 && rd_cnt == 0; k++) @(posedge clk);
        if (rd_cnt == 0) fail_now("timeout_no_rd");
        repeat (40) @(posedge clk);
        #1;
        chk("timeout_rd_cycle", first_rd - first_ne, TIMEOUT_CYC);
        chk("timeout_bytes", tx_log.size(), 6);
        chk("timeout_rd_count", rd_cnt, 3);
        if (tx_log.size() == 6) chk("timeout_last_byte", 32'(tx_log[5]), 32'h89);

        // TX stall
        do_reset();
        for (int i = 0; i < 16; i++) write_word(1'b0, DATA_W'(12'h5A0 + i));
        for (int k = 0; k < 100 && !bus.tx_valid; k++) @(posedge clk);
        @(negedge clk);
        b = bus.tx_byte;
        rd_before = rd_cnt;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.tx_byte !== b || bus.tx_valid !== 1'b1) bad++;
        end
        chk("stall_first_byte", 32'(b), 32'h05);
        chk("stall_stable", bad, 0);
        chk("stall_no_rd", rd_cnt, rd_before);
        @(posedge clk); #1;
        bus.tx_ready = 1'b1;
        repeat (11) @(posedge clk);

        // Asynchronous reset mid-burst
        @(negedge clk); #2;
        tb_rst = 1'b1;
        #1;
        chk("async_rst_outputs",
            {9'd0, bus.tx_valid, bus.fifo_rd_en, bus.tx_byte, bus.fifo_wr_en, bus.fifo_wr_data},
            32'd0);
        drive_idle();
        clear_sb();
        @(posedge clk); #1;
        tb_rst = 1'b0;
        bus.tx_ready = 1'b1;

        // Overflow sticky
        chk("overflow_clear", 32'(bus.overflow_err), 32'd0);
        force_full = 1'b1;
        write_word(1'b0, 12'h777);
        @(posedge clk); #1;
        force_full = 1'b0;
        chk("overflow_set", 32'(bus.overflow_err), 32'd1);
        repeat (20) @(posedge clk);
        #1 chk("overflow_sticky", 32'(bus.overflow_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
